// File: rtl/axi_mem_slave_pkg.sv
// Types shared by the AXI memory target and anything that talks to it.
package axi_mem_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Master-to-slave channel bundle (AW, W, B-ready, AR, R-ready).
  typedef struct packed {
    logic        awvalid;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        arvalid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rready;
  } s_axi_mosi_t;

  // Slave-to-master channel bundle (readies, B and R responses).
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        arready;
    logic        bvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_mem_slave.sv
// Single-beat AXI4 memory target backed by an on-chip word array.
// Writes go through independent AW/W holding registers; reads use a
// two-state FSM with a registered R response. Out-of-range addresses and
// burst requests (len != 0) answer SLVERR and never touch memory.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  logic [31:0] mem_q [MEM_WORDS];

  // write-side holding registers and B response
  logic        aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic        awready_q, wready_q;
  logic [3:0]  awid_q;
  logic [31:0] awaddr_q;
  logic [7:0]  awlen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;

  // read-side FSM and R response
  rd_state_e   state_q, state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rlast_q;
  logic [3:0]  rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_hs, w_hs, commit, ar_hs, r_hs;
  logic [32:0] aw_diff, ar_diff;
  logic        aw_ok, ar_ok;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  // The borrow bit of the 33-bit subtraction flags addresses below BASE_ADDR.
  assign aw_diff = {1'b0, awaddr_q} - {1'b0, BASE_ADDR};
  assign ar_diff = {1'b0, axi_mosi_i.araddr} - {1'b0, BASE_ADDR};
  assign aw_ok   = !aw_diff[32] && ({1'b0, aw_diff[31:0]} < SPAN) && (awlen_q == 8'd0);
  assign ar_ok   = !ar_diff[32] && ({1'b0, ar_diff[31:0]} < SPAN) && (axi_mosi_i.arlen == 8'd0);
  assign aw_idx  = aw_diff[IDX_W+1:2];
  assign ar_idx  = ar_diff[IDX_W+1:2];

  assign aw_hs  = axi_mosi_i.awvalid && awready_q;
  assign w_hs   = axi_mosi_i.wvalid && wready_q;
  assign commit = aw_full_q && w_full_q && (!bvalid_q || axi_mosi_i.bready);
  assign ar_hs  = (state_q == RD_IDLE) && axi_mosi_i.arvalid && arready_q;
  assign r_hs   = (state_q == RD_RESP) && rvalid_q && axi_mosi_i.rready;

  // Holding-register occupancy: a commit frees both slots for one cycle.
  always_comb begin
    aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
    w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);
  end

  // Write channel registers; readies are registered so they read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready_q <= !aw_full_d;
      wready_q  <= !w_full_d;
      if (aw_hs) begin
        awid_q   <= axi_mosi_i.awid;
        awaddr_q <= axi_mosi_i.awaddr;
        awlen_q  <= axi_mosi_i.awlen;
      end
      if (w_hs) begin
        wdata_q <= axi_mosi_i.wdata;
        wstrb_q <= axi_mosi_i.wstrb;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bid_q    <= awid_q;
        bresp_q  <= aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (axi_mosi_i.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Byte-lane memory write on commit; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (commit && aw_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[aw_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RD_IDLE;
    else     state_q <= state_d;
  end

  // Read FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (r_hs)  state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  // Read FSM output decode, taken from the state being entered.
  always_comb begin
    arready_d = (state_d == RD_IDLE);
  end

  // R response registers; a read sharing an edge with a commit sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      arready_q <= arready_d;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rlast_q  <= 1'b1;
        rid_q    <= axi_mosi_i.arid;
        rdata_q  <= ar_ok ? mem_q[ar_idx] : 32'h0;
        rresp_q  <= ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // Drive the response bundle.
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = awready_q;
    axi_miso_o.wready  = wready_q;
    axi_miso_o.arready = arready_q;
    axi_miso_o.bvalid  = bvalid_q;
    axi_miso_o.bid     = bid_q;
    axi_miso_o.bresp   = bresp_q;
    axi_miso_o.rvalid  = rvalid_q;
    axi_miso_o.rid     = rid_q;
    axi_miso_o.rdata   = rdata_q;
    axi_miso_o.rresp   = rresp_q;
    axi_miso_o.rlast   = rlast_q;
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: a write/read vector table plus
// hand-written sequences for ordering, back-pressure and reset corners.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [1:0]  OK        = 2'b00;
  localparam logic [1:0]  SE        = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  axi_mem_slave #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .axi_mosi_i (mosi),
    .axi_miso_o (miso)
  );

  typedef struct packed {
    logic [31:0] waddr;
    logic [7:0]  wlen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic [1:0]  exp_rresp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] data, input logic [3:0] strb,
                           output logic [3:0] bid, output logic [1:0] bresp);
    logic aw_pend, w_pend, aw_hs, w_hs;
    int   n;
    mosi.awvalid = 1'b1; mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len;
    mosi.wvalid  = 1'b1; mosi.wdata = data; mosi.wstrb = strb;
    mosi.bready  = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 50) begin
      aw_hs = mosi.awvalid && miso.awready;
      w_hs  = mosi.wvalid && miso.wready;
      step(); n++;
      if (aw_hs) begin mosi.awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin mosi.wvalid  = 1'b0; w_pend  = 1'b0; end
    end
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    n = 0;
    while (!miso.bvalid && n < 50) begin step(); n++; end
    chk("wr_bvalid_timeout", 64'(miso.bvalid), 64'd1);
    bid = miso.bid; bresp = miso.bresp;
    step();
    mosi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          output logic [31:0] rdata, output logic [1:0] rresp,
                          output logic [3:0] rid, output logic rlast);
    logic hs;
    int   n;
    mosi.arvalid = 1'b1; mosi.arid = id; mosi.araddr = addr; mosi.arlen = len;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      hs = miso.arready;
      step(); n++;
    end
    mosi.arvalid = 1'b0;
    chk("rd_accept_timeout", 64'(hs), 64'd1);
    chk("rd_latency_rvalid", 64'(miso.rvalid), 64'd1);
    rdata = miso.rdata; rresp = miso.rresp; rid = miso.rid; rlast = miso.rlast;
    mosi.rready = 1'b1;
    step();
    mosi.rready = 1'b0;
    chk("rd_rvalid_clear", 64'(miso.rvalid), 64'd0);
  endtask

  initial begin
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        rlast;

    //            waddr          wlen  wdata         strb  bresp raddr          rlen  rresp rdata
    vecs[0]  = '{BASE+32'h0,    8'd0, 32'h01020304, 4'hF, OK,   BASE+32'h0,    8'd0, OK,   32'h01020304};
    vecs[1]  = '{BASE+32'h10,   8'd0, 32'hDEADBEEF, 4'hF, OK,   BASE+32'h10,   8'd0, OK,   32'hDEADBEEF};
    vecs[2]  = '{BASE+32'h20,   8'd0, 32'h11223344, 4'hF, OK,   BASE+32'h20,   8'd0, OK,   32'h11223344};
    vecs[3]  = '{BASE+32'h22,   8'd0, 32'h55000000, 4'h8, OK,   BASE+32'h20,   8'd0, OK,   32'h55223344};
    vecs[4]  = '{BASE+32'h3FFC, 8'd0, 32'hCAFEF00D, 4'hF, OK,   BASE+32'h3FFC, 8'd0, OK,   32'hCAFEF00D};
    vecs[5]  = '{BASE+32'h4000, 8'd0, 32'h12345678, 4'hF, SE,   BASE+32'h4000, 8'd0, SE,   32'h0};
    vecs[6]  = '{BASE-32'h4,    8'd0, 32'hAAAAAAAA, 4'hF, SE,   BASE+32'h0,    8'd0, OK,   32'h01020304};
    vecs[7]  = '{BASE+32'h10,   8'd1, 32'h0,        4'hF, SE,   BASE+32'h3FFC, 8'd0, OK,   32'hCAFEF00D};
    vecs[8]  = '{BASE+32'h4,    8'd0, 32'h77777777, 4'h0, OK,   BASE+32'h10,   8'd0, OK,   32'hDEADBEEF};
    vecs[9]  = '{BASE+32'h4,    8'd0, 32'h33333333, 4'hF, OK,   BASE+32'h10,   8'd2, SE,   32'h0};
    vecs[10] = '{BASE+32'h4,    8'd0, 32'h00990000, 4'h4, OK,   BASE+32'h4,    8'd0, OK,   32'h33993333};

    // reset held three cycles
    mosi = '0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_miso_held", {14'b0, miso}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_miso_release", {14'b0, miso}, 64'd0);
    step();
    chk("idle_readies", {61'b0, miso.awready, miso.wready, miso.arready}, 64'h7);

    // AW and W in the same cycle: bvalid two edges after the request
    mosi.awvalid = 1'b1; mosi.awid = 4'h2; mosi.awaddr = BASE + 32'h30; mosi.awlen = 8'd0;
    mosi.wvalid  = 1'b1; mosi.wdata = 32'hDEADBEEF; mosi.wstrb = 4'hF;
    mosi.bready  = 1'b1;
    step();
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    chk("lat_bvalid_after_accept", 64'(miso.bvalid), 64'd0);
    chk("lat_awready_full", 64'(miso.awready), 64'd0);
    step();
    chk("lat_bvalid_after_commit", 64'(miso.bvalid), 64'd1);
    chk("lat_bid", 64'(miso.bid), 64'h2);
    chk("lat_bresp", 64'(miso.bresp), 64'(OK));
    chk("lat_awready_freed", 64'(miso.awready), 64'd1);
    step();
    chk("lat_bvalid_cleared", 64'(miso.bvalid), 64'd0);
    mosi.bready = 1'b0;
    axi_read(4'h1, BASE + 32'h30, 8'd0, rdata, rresp, rid, rlast);
    chk("lat_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("lat_rlast", 64'(rlast), 64'd1);

    // table of write-then-read vectors
    for (int i = 0; i < 11; i++) begin
      axi_write(4'(i), vecs[i].waddr, vecs[i].wlen, vecs[i].wdata, vecs[i].wstrb, bid, bresp);
      chk($sformatf("vec%0d_bresp", i), 64'(bresp), 64'(vecs[i].exp_bresp));
      chk($sformatf("vec%0d_bid", i), 64'(bid), 64'(i));
      axi_read(4'(15 - i), vecs[i].raddr, vecs[i].rlen, rdata, rresp, rid, rlast);
      chk($sformatf("vec%0d_rresp", i), 64'(rresp), 64'(vecs[i].exp_rresp));
      chk($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_rid", i), 64'(rid), 64'(15 - i));
      chk($sformatf("vec%0d_rlast", i), 64'(rlast), 64'd1);
    end

    // W leads AW by three cycles, byte-lane merge into an existing word
    axi_write(4'h3, BASE + 32'h40, 8'd0, 32'h11223344, 4'hF, bid, bresp);
    mosi.wvalid = 1'b1; mosi.wdata = 32'h0000AA00; mosi.wstrb = 4'h2;
    step();
    mosi.wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wfirst_wready_%0d", k), 64'(miso.wready), 64'd0);
      chk($sformatf("wfirst_bvalid_%0d", k), 64'(miso.bvalid), 64'd0);
      step();
    end
    mosi.awvalid = 1'b1; mosi.awid = 4'h4; mosi.awaddr = BASE + 32'h40; mosi.awlen = 8'd0;
    mosi.bready = 1'b1;
    step();
    mosi.awvalid = 1'b0;
    step();
    chk("wfirst_bvalid", 64'(miso.bvalid), 64'd1);
    chk("wfirst_bid", 64'(miso.bid), 64'h4);
    step();
    mosi.bready = 1'b0;
    axi_read(4'h5, BASE + 32'h40, 8'd0, rdata, rresp, rid, rlast);
    chk("wfirst_rdata", 64'(rdata), 64'h1122AA44);

    // R back-pressure: payload holds, second AR waits for the handshake
    chk("rstall_arready_idle", 64'(miso.arready), 64'd1);
    mosi.arvalid = 1'b1; mosi.arid = 4'h5; mosi.araddr = BASE + 32'h10; mosi.arlen = 8'd0;
    mosi.rready = 1'b0;
    step();
    mosi.arid = 4'h6; mosi.araddr = BASE + 32'h40;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rstall_rvalid_%0d", k), 64'(miso.rvalid), 64'd1);
      chk($sformatf("rstall_rdata_%0d", k), 64'(miso.rdata), 64'hDEADBEEF);
      chk($sformatf("rstall_rid_%0d", k), 64'(miso.rid), 64'h5);
      chk($sformatf("rstall_arready_%0d", k), 64'(miso.arready), 64'd0);
      step();
    end
    mosi.rready = 1'b1;
    step();
    mosi.rready = 1'b0;
    chk("rstall_rvalid_dropped", 64'(miso.rvalid), 64'd0);
    chk("rstall_arready_back", 64'(miso.arready), 64'd1);
    step();
    mosi.arvalid = 1'b0;
    chk("rstall_2nd_rvalid", 64'(miso.rvalid), 64'd1);
    chk("rstall_2nd_rid", 64'(miso.rid), 64'h6);
    chk("rstall_2nd_rdata", 64'(miso.rdata), 64'h1122AA44);
    mosi.rready = 1'b1;
    step();
    mosi.rready = 1'b0;

    // B back-pressure blocks the second commit; handshake and commit share an edge
    mosi.bready = 1'b0;
    mosi.awvalid = 1'b1; mosi.awid = 4'h7; mosi.awaddr = BASE + 32'h50; mosi.awlen = 8'd0;
    mosi.wvalid  = 1'b1; mosi.wdata = 32'h50505050; mosi.wstrb = 4'hF;
    step();
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    step();
    chk("bstall_bvalid", 64'(miso.bvalid), 64'd1);
    chk("bstall_bid_first", 64'(miso.bid), 64'h7);
    mosi.awvalid = 1'b1; mosi.awid = 4'h8; mosi.awaddr = BASE + 32'h54;
    mosi.wvalid  = 1'b1; mosi.wdata = 32'h54545454;
    step();
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bstall_hold_bid_%0d", k), 64'(miso.bid), 64'h7);
      chk($sformatf("bstall_hold_bvalid_%0d", k), 64'(miso.bvalid), 64'd1);
      chk($sformatf("bstall_awready_%0d", k), 64'(miso.awready), 64'd0);
      step();
    end
    mosi.bready = 1'b1;
    step();
    chk("bstall_back2back_bvalid", 64'(miso.bvalid), 64'd1);
    chk("bstall_back2back_bid", 64'(miso.bid), 64'h8);
    step();
    chk("bstall_bvalid_cleared", 64'(miso.bvalid), 64'd0);
    mosi.bready = 1'b0;
    axi_read(4'h9, BASE + 32'h54, 8'd0, rdata, rresp, rid, rlast);
    chk("bstall_rdata_second", 64'(rdata), 64'h54545454);

    // reset with bvalid pending and AW held
    mosi.awvalid = 1'b1; mosi.awid = 4'h9; mosi.awaddr = BASE + 32'h60; mosi.awlen = 8'd0;
    mosi.wvalid  = 1'b1; mosi.wdata = 32'h66666666; mosi.wstrb = 4'hF;
    step();
    mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
    step();
    mosi.awvalid = 1'b1; mosi.awid = 4'hA; mosi.awaddr = BASE + 32'h64;
    step();
    mosi.awvalid = 1'b0;
    chk("midrst_pre_bvalid", 64'(miso.bvalid), 64'd1);
    chk("midrst_pre_awfull", 64'(miso.awready), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_miso", {14'b0, miso}, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_readies", {61'b0, miso.awready, miso.wready, miso.arready}, 64'h7);
    chk("midrst_bvalid", 64'(miso.bvalid), 64'd0);
    axi_write(4'hB, BASE + 32'h64, 8'd0, 32'h12121212, 4'hF, bid, bresp);
    chk("midrst_bid", 64'(bid), 64'hB);
    chk("midrst_bresp", 64'(bresp), 64'(OK));
    axi_read(4'hC, BASE + 32'h64, 8'd0, rdata, rresp, rid, rlast);
    chk("midrst_rdata_new", 64'(rdata), 64'h12121212);
    axi_read(4'hD, BASE + 32'h60, 8'd0, rdata, rresp, rid, rlast);
    chk("midrst_rdata_committed", 64'(rdata), 64'h66666666);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
